irq_ctrl: RTL

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/irq_ctrl.sv
// irq_ctrl: 32-line interrupt controller with a memory-mapped register block.
// Each line can be edge- or level-triggered. Lines are masked by ENABLE and by
// a fixed set of reserved lines. cpu_irq is a registered copy of the active lines.
// Register map, decoded on iomem_addr[3:2]:
//   0x0 ENABLE  read/write
//   0x4 MODE    read/write (1 = edge, 0 = level)
//   0x8 PENDING read, write-1-to-clear (edge lines only)
//   0xC STATUS  read-only {any_active, 26'b0, lowest active index}
module irq_ctrl #(
    parameter logic [31:0] DEFAULT_ENABLE = 32'h0000_0030,
    parameter logic [31:0] DEFAULT_MODE   = 32'hFFFF_FFFF,
    parameter logic [31:0] RESERVED_MASK  = 32'h0000_0007
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] src_irq,
    input  logic [31:0] eoi,
    output logic [31:0] cpu_irq,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata
);

    localparam logic [1:0] ADDR_ENABLE  = 2'd0;
    localparam logic [1:0] ADDR_MODE    = 2'd1;
    localparam logic [1:0] ADDR_PENDING = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    // Architectural state
    logic [31:0] enable_reg;
    logic [31:0] mode_reg;
    logic [31:0] pending_reg;
    logic [31:0] src_q_reg;
    logic [31:0] eoi_q_reg;
    logic [31:0] cpu_irq_reg;
    logic        ready_reg;
    logic [31:0] rdata_reg;

    // Combinational helpers
    logic        access;
    logic        wr_en;
    logic        wr_enable;
    logic        wr_mode;
    logic        wr_pending;
    logic [31:0] byte_mask;
    logic [31:0] enable_next;
    logic [31:0] mode_next;
    logic [31:0] mode_change;
    logic [31:0] w1c;
    logic [31:0] src_rise;
    logic [31:0] eoi_rise;
    logic [31:0] edge_clr;
    logic [31:0] pending_next;
    logic [31:0] active;
    logic [4:0]  status_idx;
    logic [31:0] status_word;
    logic [31:0] rdata_next;
    logic        unused_addr;

    // Only address bits [3:2] select a register; the rest are ignored.
    assign unused_addr = ^{iomem_addr[31:4], iomem_addr[1:0]};

    // An access is accepted on the first edge valid is seen while no
    // completion pulse is out, which forces a gap cycle between accesses.
    assign access     = iomem_valid & ~ready_reg;
    assign wr_en      = access & (|iomem_wstrb);
    assign wr_enable  = wr_en & (iomem_addr[3:2] == ADDR_ENABLE);
    assign wr_mode    = wr_en & (iomem_addr[3:2] == ADDR_MODE);
    assign wr_pending = wr_en & (iomem_addr[3:2] == ADDR_PENDING);

    // Expand byte strobes into a per-bit write mask.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_byte_mask
            assign byte_mask[gi*8 +: 8] = {8{iomem_wstrb[gi]}};
        end
    endgenerate

    assign enable_next = (enable_reg & ~byte_mask) | (iomem_wdata & byte_mask);
    assign mode_next   = (mode_reg & ~byte_mask) | (iomem_wdata & byte_mask);

    // Lines whose mode flips on this edge lose their pending state.
    assign mode_change = wr_mode ? (mode_next ^ mode_reg) : 32'h0;
    assign w1c         = wr_pending ? (iomem_wdata & byte_mask) : 32'h0;

    assign src_rise = src_irq & ~src_q_reg;
    assign eoi_rise = eoi & ~eoi_q_reg;
    assign edge_clr = eoi_rise | w1c;

    // Per-line pending update: mode flip clears, edge lines set-over-clear,
    // level lines simply follow the source.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_pending
            assign pending_next[gi] = mode_change[gi] ? 1'b0 :
                                      mode_reg[gi]    ? (src_rise[gi] | (pending_reg[gi] & ~edge_clr[gi])) :
                                                        src_irq[gi];
        end
    endgenerate

    assign active = pending_reg & enable_reg & ~RESERVED_MASK;

    // Priority encoder: scan from the top so the lowest active index wins.
    always_comb begin
        status_idx = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (active[i]) begin
                status_idx = i[4:0];
            end
        end
    end

    assign status_word = {|active, 26'b0, status_idx};

    // Read mux; PENDING returns the value held before this edge's update.
    always_comb begin
        rdata_next = 32'h0;
        case (iomem_addr[3:2])
            ADDR_ENABLE:  rdata_next = enable_reg;
            ADDR_MODE:    rdata_next = mode_reg;
            ADDR_PENDING: rdata_next = pending_reg;
            ADDR_STATUS:  rdata_next = status_word;
            default:      rdata_next = 32'h0;
        endcase
    end

    // Bus side: configuration registers and the one-cycle completion pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable_reg <= DEFAULT_ENABLE;
            mode_reg   <= DEFAULT_MODE;
            ready_reg  <= 1'b0;
            rdata_reg  <= 32'h0;
        end else begin
            if (wr_enable) begin
                enable_reg <= enable_next;
            end
            if (wr_mode) begin
                mode_reg <= mode_next;
            end
            if (access) begin
                ready_reg <= 1'b1;
                rdata_reg <= rdata_next;
            end else begin
                ready_reg <= 1'b0;
                rdata_reg <= 32'h0;
            end
        end
    end

    // Interrupt side: input history, pending state and the registered output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_q_reg   <= 32'h0;
            eoi_q_reg   <= 32'h0;
            pending_reg <= 32'h0;
            cpu_irq_reg <= 32'h0;
        end else begin
            src_q_reg   <= src_irq;
            eoi_q_reg   <= eoi;
            pending_reg <= pending_next;
            cpu_irq_reg <= active;
        end
    end

    assign cpu_irq     = cpu_irq_reg;
    assign iomem_ready = ready_reg;
    assign iomem_rdata = rdata_reg;

endmodule
